// File: rtl/up_axi_lite_master.sv
// up request/ack bus to AXI-lite master bridge.
// One single-beat transaction outstanding at a time.
module up_axi_lite_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter bit WRITE_PRIORITY = 1'b1
) (
    input  logic                     aclk,
    input  logic                     arstn,

    input  logic                     up_wreq,
    input  logic [ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    output logic                     up_werr,

    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    output logic                     up_rerr,

    output logic                     busy,

    output logic                     m_axi_awvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]               m_axi_awprot,
    input  logic                     m_axi_awready,

    output logic                     m_axi_wvalid,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    input  logic                     m_axi_wready,

    input  logic                     m_axi_bvalid,
    input  logic [1:0]               m_axi_bresp,
    output logic                     m_axi_bready,

    output logic                     m_axi_arvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]               m_axi_arprot,
    input  logic                     m_axi_arready,

    input  logic                     m_axi_rvalid,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    output logic                     m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t state;
    logic   done_hold;
    logic   take_wr;
    logic   take_rd;
    logic   aw_left;
    logic   w_left;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Request arbitration and per-channel "still waiting" flags
    always_comb begin
        take_wr = up_wreq && (WRITE_PRIORITY || !up_rreq);
        take_rd = up_rreq && (!WRITE_PRIORITY || !up_wreq);
        aw_left = m_axi_awvalid && !m_axi_awready;
        w_left  = m_axi_wvalid && !m_axi_wready;
    end

    // Transaction FSM; DONE lasts two cycles (ack cycle, then quiet cycle)
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state         <= IDLE;
            done_hold     <= 1'b0;
            up_wack       <= 1'b0;
            up_werr       <= 1'b0;
            up_rack       <= 1'b0;
            up_rerr       <= 1'b0;
            up_rdata      <= 32'h0;
            busy          <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= 32'h0;
            m_axi_wstrb   <= 4'h0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
        end else begin
            up_wack     <= 1'b0;
            up_rack     <= 1'b0;
            m_axi_wstrb <= 4'hF;
            unique case (state)
                IDLE: begin
                    if (take_wr) begin
                        m_axi_awaddr  <= {up_waddr, 2'b00};
                        m_axi_wdata   <= up_wdata;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        busy          <= 1'b1;
                        state         <= WR_REQ;
                    end else if (take_rd) begin
                        m_axi_araddr  <= {up_raddr, 2'b00};
                        m_axi_arvalid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (!aw_left && !w_left) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        up_wack      <= 1'b1;
                        up_werr      <= (m_axi_bresp != 2'b00);
                        state        <= DONE;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        up_rdata     <= m_axi_rdata;
                        up_rack      <= 1'b1;
                        up_rerr      <= (m_axi_rresp != 2'b00);
                        m_axi_rready <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (done_hold) begin
                        done_hold <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        done_hold <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
